clkdiv_period_monitor: RTL and testbench
========================================

Name: clkdiv_period_monitor

Overview:
- Receiver-side companion to the team's toggle-flop clock divider.
- Takes an asynchronous divided clock `clk_in`, synchronises it into the fast `clk` domain and measures its period in `clk` cycles.
- Declares lock once the period is stable, and flags mismatch or loss of the divided clock.
- Used on-board and in benches to confirm a divider's output ratio.

Parameters:
- CNT_W, 16: width of the period counter and the `period` output.
- LOCK_CNT, 4: number of consecutive matching periods needed to assert `locked`; must be ≥ 1.
- TOL, 0: maximum absolute difference, in `clk` cycles, between successive periods still counted as a match.
- MAX_PERIOD, 1000: cycles without a rising edge before timeout; must be < 2^CNT_W.

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- clk_in, input, 1: divided clock under test; asynchronous to `clk`.
- period, output, CNT_W: last measured rising-to-rising period in `clk` cycles.
- period_valid, output, 1: one-cycle pulse when `period` updates.
- locked, output, 1: high while in LOCKED.
- mismatch, output, 1: one-cycle pulse when a period differs from the previous one by more than TOL.
- timeout, output, 1: one-cycle pulse when MAX_PERIOD elapses with no rising edge.
- duty_high, output, CNT_W: high-time of the last period. Exists only with DUTY_CHECK_EN.
- duty_err, output, 1: one-cycle duty-cycle error pulse. Exists only with DUTY_CHECK_EN.

Behaviour:
- Reset (synchronous, active-high)
  - `rst`=1 at a `clk` edge clears all state.
  - Outputs after reset: `period`=0, `period_valid`=0, `locked`=0, `mismatch`=0, `timeout`=0, `duty_high`=0, `duty_err`=0.
  - Synchroniser flops are cleared to 0.
  - State goes to IDLE and `cnt`=0.
  - `rst` asserted mid-measurement discards the partial count, and `locked` drops on the same edge.
- Synchroniser and edge detect
  - Stages: s1 <= clk_in, s2 <= s1, s3 <= s2.
  - rise = s2 & ~s3.
  - Latency: if `clk_in` is sampled high at edge k, rise is true during cycle k+1→k+2, and registered outputs update at edge k+2.
- Counter
  - Without rise: `cnt` <= `cnt`+1, saturating at 2^CNT_W−1.
  - On rise: `cnt` <= 1.
  - Result: `cnt` at a rise equals the exact number of `clk` cycles since the previous rise.
- State machine: IDLE, ARM, TRACK, LOCKED. A match means |`cnt` − `period`| ≤ TOL; the match counter `mcnt` is internal.
  - IDLE: on rise → ARM; `cnt` <= 1; no output change.
  - ARM, on rise:
    - `period` <= `cnt`; `period_valid` pulses.
    - → TRACK with `mcnt`=0.
    - The first partial interval after IDLE is never reported.
  - TRACK, on rise:
    - `period` <= `cnt`; `period_valid` pulses.
    - Match: `mcnt`++. When the incremented `mcnt` reaches LOCK_CNT → LOCKED, with `locked`=1 from that edge.
    - Mismatch: `mismatch` pulses and `mcnt` <= 0.
  - LOCKED, on rise:
    - `period` updates; `period_valid` pulses.
    - Mismatch: `mismatch` pulses, `locked` <= 0, → TRACK with `mcnt`=0.
  - Timeout, in ARM, TRACK or LOCKED:
    - When `cnt` reaches MAX_PERIOD with no rise, `timeout` pulses.
    - → IDLE, `locked` <= 0, `cnt` <= 0.
    - `period` holds its last value.
  - Simultaneous rise and `cnt`==MAX_PERIOD: the rise wins and no timeout occurs.
- Width rules
  - Comparison uses CNT_W+1-bit signed difference; no wrap.
  - A saturated `cnt` can never match, because saturation implies a timeout has already occurred.
- Timing: all outputs are registered, with no combinational path from `clk_in`.

Optional Feature:
- Macro: DUTY_CHECK_EN.
- Defined:
  - Count `clk` cycles with s2=1 since the last rise into `hcnt`.
  - On each rise: `duty_high` <= `hcnt`.
  - `duty_err` pulses, in the same cycle as `period_valid`, if |2·`hcnt` − `cnt`| > 2·TOL+1; this allows the ±1 imbalance of an odd period.
  - `duty_err` does not affect the state machine.
- Undefined: `duty_high` and `duty_err` ports and their logic are absent.

Test Plan:
- Period 4, lock: `clk_in` period 4 `clk`s, 50% duty, LOCK_CNT=4.
  - First `period_valid` shows 4.
  - `locked`=1 on the edge of the 4th matching period after that (5th period measured); no `mismatch`.
- Period change: after lock, period changes 4→6.
  - One `mismatch` pulse, `locked`=0 same edge, `period`=6.
  - Relock after 4 more periods of 6.
- Loss of clock: hold `clk_in` low after lock, MAX_PERIOD=20.
  - `timeout` pulses exactly 20 cycles after the last rise (`cnt` hits 20); state IDLE, `locked`=0, `period` still 4.
- Tolerance: TOL=1 with periods alternating 5,6,5,6 → lock reached, no `mismatch`. Same with TOL=0 → `mismatch` on every period, never locks.
- Reset mid-lock: `rst`=1 for 1 cycle while locked.
  - Next edge: all outputs 0, state IDLE.
  - First `period_valid` appears only at the second rise after reset.
- DUTY_CHECK_EN: period 8, high 2 → `duty_high`=2, `duty_err` pulses. Period 8, high 4 → no `duty_err`.

Source files
------------

// File: rtl/clkdiv_period_monitor.sv
// Measures the period of an asynchronous divided clock in clk cycles, declares lock
// on a stable period, and flags mismatch/timeout. Optional duty check: DUTY_CHECK_EN.
module clkdiv_period_monitor #(
  parameter int CNT_W      = 16,
  parameter int LOCK_CNT   = 4,
  parameter int TOL        = 0,
  parameter int MAX_PERIOD = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             timeout
`ifdef DUTY_CHECK_EN
  ,
  output logic [CNT_W-1:0] duty_high,
  output logic             duty_err
`endif
);

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]        MAXP  = CNT_W'(MAX_PERIOD);
  localparam logic [MC_W-1:0]         MLAST = MC_W'(LOCK_CNT - 1);
  localparam logic signed [CNT_W:0]   TOL_P = (CNT_W+1)'(TOL);

  typedef enum logic [1:0] {IDLE, ARM, TRACK, LOCKED} state_t;

  state_t                state, state_nxt;
  logic                  s1, s2, s3, rise;
  logic [CNT_W-1:0]      cnt, period_nxt;
  logic [MC_W-1:0]       mcnt, mcnt_nxt;
  logic signed [CNT_W:0] diff;
  logic                  match, tmo;
  logic                  pv_nxt, mm_nxt, to_nxt, lk_nxt;

  assign rise  = s2 & ~s3;
  // One extra bit keeps the signed difference from wrapping.
  assign diff  = $signed({1'b0, cnt}) - $signed({1'b0, period});
  assign match = (diff <= TOL_P) && (diff >= -TOL_P);
  assign tmo   = (state != IDLE) && !rise && (cnt == MAXP);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mcnt_nxt  = mcnt;
    case (state)
      IDLE: if (rise) state_nxt = ARM;
      ARM: begin
        if (rise) begin
          state_nxt = TRACK;
          mcnt_nxt  = '0;
        end else if (tmo) state_nxt = IDLE;
      end
      TRACK: begin
        if (rise) begin
          if (!match) mcnt_nxt = '0;
          else if (mcnt == MLAST) begin
            state_nxt = LOCKED;
            mcnt_nxt  = '0;
          end else mcnt_nxt = mcnt + 1'b1;
        end else if (tmo) state_nxt = IDLE;
      end
      LOCKED: begin
        if (rise) begin
          if (!match) begin
            state_nxt = TRACK;
            mcnt_nxt  = '0;
          end
        end else if (tmo) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pv_nxt     = rise && (state != IDLE);
    period_nxt = pv_nxt ? cnt : period;
    mm_nxt     = rise && ((state == TRACK) || (state == LOCKED)) && !match;
    to_nxt     = tmo;
    lk_nxt     = (state_nxt == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      cnt          <= '0;
      mcnt         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      mismatch     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      s1           <= clk_in;
      s2           <= s1;
      s3           <= s2;
      if (rise)            cnt <= CNT_W'(1);
      else if (tmo)        cnt <= '0;
      else if (cnt != '1)  cnt <= cnt + 1'b1;
      mcnt         <= mcnt_nxt;
      period       <= period_nxt;
      period_valid <= pv_nxt;
      locked       <= lk_nxt;
      mismatch     <= mm_nxt;
      timeout      <= to_nxt;
    end
  end

`ifdef DUTY_CHECK_EN
  localparam logic signed [CNT_W+1:0] DTH = (CNT_W+2)'(2*TOL + 1);

  logic [CNT_W-1:0]        hcnt;
  logic signed [CNT_W+1:0] ddiff;
  logic                    derr_nxt;

  // 2*high - period; an odd period legitimately leaves a +/-1 imbalance.
  assign ddiff    = $signed({1'b0, hcnt, 1'b0}) - $signed({2'b00, cnt});
  assign derr_nxt = pv_nxt && ((ddiff > DTH) || (ddiff < -DTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt      <= '0;
      duty_high <= '0;
      duty_err  <= 1'b0;
    end else begin
      if (rise)                    hcnt <= CNT_W'(1);
      else if (s2 && hcnt != '1)   hcnt <= hcnt + 1'b1;
      if (rise) duty_high <= hcnt;
      duty_err <= derr_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_clkdiv_period_monitor.sv
// Bench for clkdiv_period_monitor: two instances (TOL=0, TOL=1) share one clk_in and are
// compared every cycle against an event-level model built from rise times.
module tb_clkdiv_period_monitor;
  localparam int MAXP = 20;
  localparam int LCK  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_in = 1'b0;
  logic [15:0] period_o [2];
  logic        pv_o [2], lk_o [2], mm_o [2], to_o [2];
`ifdef DUTY_CHECK_EN
  logic [15:0] dh_o [2];
  logic        de_o [2];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    clkdiv_period_monitor #(.CNT_W(16), .LOCK_CNT(LCK), .TOL(g), .MAX_PERIOD(MAXP)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .clk_in       (clk_in),
      .period       (period_o[g]),
      .period_valid (pv_o[g]),
      .locked       (lk_o[g]),
      .mismatch     (mm_o[g]),
      .timeout      (to_o[g])
`ifdef DUTY_CHECK_EN
      ,
      .duty_high    (dh_o[g]),
      .duty_err     (de_o[g])
`endif
    );
  end

  int tests = 0, fails = 0;
  int cyc = 0, last_rise = 0, hcur = 0;
  logic prev_cin = 1'b0;
  int rq [$];   // clk edge at which each driven rising edge is processed
  int hq [$];   // high time of each completed clk_in pulse
  int m_st [2], m_period [2], m_mcnt [2], m_dh [2];
  logic m_pv [2], m_mm [2], m_to [2], m_lk [2], m_de [2];

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic void chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d cyc %0d: got %0d expected %0d", tag, idx, cyc, obs, exp);
    end
  endfunction

  // Reference: a rise is seen two edges after clk_in is first sampled high;
  // period is the edge distance between consecutive rises.
  function automatic void model_edge(input logic r);
    logic is_rise;
    int   iv, dh;
    is_rise = (rq.size() > 0) && (rq[0] == cyc);
    if (is_rise) void'(rq.pop_front());
    if (r) begin
      rq.delete();
      for (int i = 0; i < 2; i++) begin
        m_st[i] = 0; m_period[i] = 0; m_mcnt[i] = 0;
        m_pv[i] = 0; m_mm[i] = 0; m_to[i] = 0; m_lk[i] = 0; m_dh[i] = 0; m_de[i] = 0;
      end
      return;
    end
    iv = cyc - last_rise;
    dh = 0;
    if (is_rise && hq.size() > 0) dh = hq.pop_front();
    for (int i = 0; i < 2; i++) begin
      m_pv[i] = 0; m_mm[i] = 0; m_to[i] = 0; m_de[i] = 0;
      if (is_rise) begin
        case (m_st[i])
          0: m_st[i] = 1;
          1: begin m_pv[i] = 1; m_period[i] = iv; m_st[i] = 2; m_mcnt[i] = 0; end
          default: begin
            m_pv[i] = 1;
            if (iabs(iv - m_period[i]) <= i) begin
              if (m_st[i] == 2) begin
                m_mcnt[i]++;
                if (m_mcnt[i] == LCK) m_st[i] = 3;
              end
            end else begin
              m_mm[i] = 1; m_mcnt[i] = 0; m_st[i] = 2;
            end
            m_period[i] = iv;
          end
        endcase
        if (m_pv[i]) begin
          m_dh[i] = dh;
          m_de[i] = iabs(2*dh - iv) > 2*i + 1;
        end
      end else if (m_st[i] != 0 && iv == MAXP) begin
        m_to[i] = 1; m_st[i] = 0;
      end
      m_lk[i] = (m_st[i] == 3);
    end
    if (is_rise) last_rise = cyc;
  endfunction

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("period",       i, 32'(period_o[i]), m_period[i]);
      chk("period_valid", i, 32'(pv_o[i]),     32'(m_pv[i]));
      chk("locked",       i, 32'(lk_o[i]),     32'(m_lk[i]));
      chk("mismatch",     i, 32'(mm_o[i]),     32'(m_mm[i]));
      chk("timeout",      i, 32'(to_o[i]),     32'(m_to[i]));
`ifdef DUTY_CHECK_EN
      if (m_pv[i]) begin
        chk("duty_high", i, 32'(dh_o[i]), m_dh[i]);
        chk("duty_err",  i, 32'(de_o[i]), 32'(m_de[i]));
      end
`endif
    end
  endtask

  task automatic tick(input logic cin, input logic r);
    if (cin && !prev_cin) begin
      rq.push_back(cyc + 3);
      hcur = 0;
    end
    if (!cin && prev_cin) hq.push_back(hcur);
    if (cin) hcur++;
    clk_in   = cin;
    rst      = r;
    prev_cin = cin;
    @(posedge clk);
    cyc++;
    model_edge(r);
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic pulses(input int p, input int h, input int n);
    for (int k = 0; k < n; k++)
      for (int j = 0; j < p; j++) tick(j < h, 1'b0);
  endtask

  initial begin
    int p, h;
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    chk("rst_period", 0, 32'(period_o[0]), 0);
    chk("rst_locked", 1, 32'(lk_o[1]), 0);

    // Period 4, 50% duty: lock after the 5th measured period.
    pulses(4, 2, 8);
    chk("lock4", 0, 32'(lk_o[0]), 1);
    chk("lock4_period", 1, 32'(period_o[1]), 4);

    // Period change 4 -> 6 then relock.
    pulses(6, 3, 7);
    chk("relock6", 0, 32'(lk_o[0]), 1);
    chk("relock6_period", 0, 32'(period_o[0]), 6);

    // Loss of clock: timeout, period holds.
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b0);
    chk("loss_locked", 0, 32'(lk_o[0]), 0);
    chk("loss_period", 0, 32'(period_o[0]), 6);

    // Alternating 5,6: TOL=1 locks, TOL=0 never does.
    for (int k = 0; k < 12; k++) pulses(5 + (k % 2), 2, 1);
    chk("tol1_locked", 1, 32'(lk_o[1]), 1);
    chk("tol0_locked", 0, 32'(lk_o[0]), 0);

    // Reset mid-lock.
    tick(1'b0, 1'b1);
    chk("rst_mid_locked", 1, 32'(lk_o[1]), 0);
    chk("rst_mid_period", 1, 32'(period_o[1]), 0);
    pulses(4, 2, 4);
    chk("post_rst_period", 0, 32'(period_o[0]), 4);

    // Period exactly MAX_PERIOD: the rise wins over timeout.
    pulses(MAXP, 5, 4);
    chk("maxp_period", 0, 32'(period_o[0]), MAXP);

`ifdef DUTY_CHECK_EN
    pulses(8, 2, 4);
    pulses(8, 4, 4);
    pulses(7, 3, 4);
`endif

    // Randomized periods and duty, including ones past MAX_PERIOD.
    for (int k = 0; k < 40; k++) begin
      p = $urandom_range(24, 2);
      h = $urandom_range(p - 1, 1);
      pulses(p, h, $urandom_range(6, 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
